// File: rtl/ring_trim_cal_pkg.sv
// ring_cal_pkg: shared types, trim constants and the level-to-thermometer helper.
// Revision 1.0
`default_nettype none

package ring_cal_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_OSC_RST = 3'd1,
    S_SETTLE  = 3'd2,
    S_MEASURE = 3'd3,
    S_ADJUST  = 3'd4,
    S_LOCKED  = 3'd5,
    S_FAIL    = 3'd6
  } state_t;

  localparam int TRIM_W    = 26;
  localparam int LEVEL_MAX = 26;
  localparam int LEVEL_W   = 5;

  function automatic logic [TRIM_W-1:0] level_to_therm(input logic [LEVEL_W-1:0] lvl);
    logic [TRIM_W-1:0] t;
    t = '0;
    for (int i = 0; i < TRIM_W; i++) begin
      if (i < int'(lvl)) t[i] = 1'b1;
    end
    return t;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ring_trim_cal_if.sv
// ring_trim_cal_if: config/status bundle between housekeeping registers and the calibrator.
// Revision 1.0
`default_nettype none

interface ring_trim_cal_if
  import ring_cal_pkg::*;
#(
  parameter int CNT_W = 16
);
  logic                start;
  logic [LEVEL_W-1:0]  init_level;
  logic [CNT_W-1:0]    target_cnt;
  logic [7:0]          tol;
  logic                osc_div_in;
  logic                osc_reset;
  logic [TRIM_W-1:0]   trim;
  logic [LEVEL_W-1:0]  level;
  logic                busy;
  logic                locked;
  logic                fail;
  logic [CNT_W-1:0]    last_count;

  modport master (
    output start, init_level, target_cnt, tol, osc_div_in,
    input  osc_reset, trim, level, busy, locked, fail, last_count
  );

  modport slave (
    input  start, init_level, target_cnt, tol, osc_div_in,
    output osc_reset, trim, level, busy, locked, fail, last_count
  );
endinterface

`default_nettype wire

// File: rtl/ring_trim_cal_edge_counter.sv
// ring_edge_counter: synchronizes the divided ring clock and counts its rising edges (saturating).
// Revision 1.0
`default_nettype none

module ring_edge_counter #(
  parameter int CNT_W = 16
) (
  input  wire logic             clk,
  input  wire logic             resetn,
  input  wire logic             i_osc,
  input  wire logic             i_clr,
  input  wire logic             i_en,
  output logic [CNT_W-1:0]      o_count
);

  logic [1:0]       r_sync;
  logic             r_prev;
  logic [CNT_W-1:0] r_count;
  logic             w_rise;

  assign w_rise  = r_sync[1] & ~r_prev;
  assign o_count = r_count;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_sync  <= 2'b00;
      r_prev  <= 1'b0;
      r_count <= '0;
    end else begin
      r_sync <= {r_sync[0], i_osc};
      r_prev <= r_sync[1];
      if (i_clr) begin
        r_count <= '0;
      end else if (i_en && w_rise && (r_count != {CNT_W{1'b1}})) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ring_trim_cal.sv
// ring_trim_cal: closed-loop trim calibration of the 2x13-stage ring oscillator.
// Optional continuous re-measurement while locked: define RING_CAL_TRACK_EN. Revision 1.0
`default_nettype none

module ring_trim_cal
  import ring_cal_pkg::*;
#(
  parameter int WINDOW      = 1024,
  parameter int CNT_W       = 16,
  parameter int SETTLE      = 64,
  parameter int OSC_RST_CYC = 16,
  parameter int MAX_ITER    = 32
) (
  input wire logic       clk,
  input wire logic       resetn,
  ring_trim_cal_if.slave bus
);

  localparam int TIM_W  = $clog2(SETTLE + WINDOW + OSC_RST_CYC + 2);
  localparam int ITER_W = $clog2(MAX_ITER + 1);

  state_t             r_state, w_state_nx;
  logic [TIM_W-1:0]   r_tim, w_tim_nx;
  logic [ITER_W-1:0]  r_iter, w_iter_nx;
  logic [LEVEL_W-1:0] r_level, w_level_nx;
  logic               r_locked, w_locked_nx;
  logic               r_fail, w_fail_nx;
  logic               r_busy, w_busy_nx;
  logic               r_osc_reset, w_osc_reset_nx;
  logic [CNT_W-1:0]   r_last_count, w_last_count_nx;

  logic               w_clr, w_en;
  logic [CNT_W-1:0]   w_count;

  ring_edge_counter #(.CNT_W(CNT_W)) u_edge_counter (
    .clk     (clk),
    .resetn  (resetn),
    .i_osc   (bus.osc_div_in),
    .i_clr   (w_clr),
    .i_en    (w_en),
    .o_count (w_count)
  );

  // Tolerance band evaluated one bit wider so target+tol cannot wrap.
  logic [CNT_W:0]     w_cnt_x, w_tgt_x, w_tol_x, w_lo, w_hi;
  logic               w_in_tol, w_fast, w_step_fail, w_start_ok;
  logic [LEVEL_W-1:0] w_level_step, w_init_clamp;
  logic [ITER_W-1:0]  w_iter_inc;

  assign w_cnt_x      = {1'b0, w_count};
  assign w_tgt_x      = {1'b0, bus.target_cnt};
  assign w_tol_x      = (CNT_W+1)'(bus.tol);
  assign w_hi         = w_tgt_x + w_tol_x;
  assign w_lo         = (w_tgt_x >= w_tol_x) ? (w_tgt_x - w_tol_x) : '0;
  assign w_in_tol     = (w_cnt_x >= w_lo) && (w_cnt_x <= w_hi);
  assign w_fast       = (w_cnt_x > w_hi);
  assign w_step_fail  = w_fast ? (r_level == LEVEL_W'(LEVEL_MAX)) : (r_level == '0);
  assign w_level_step = w_fast ? (r_level + 1'b1) : (r_level - 1'b1);
  assign w_iter_inc   = r_iter + 1'b1;
  assign w_init_clamp = (bus.init_level > LEVEL_W'(LEVEL_MAX)) ? LEVEL_W'(LEVEL_MAX)
                                                                : bus.init_level;
  assign w_start_ok   = bus.start && !r_busy;

  always_comb begin
    w_state_nx      = r_state;
    w_tim_nx        = r_tim;
    w_iter_nx       = r_iter;
    w_level_nx      = r_level;
    w_locked_nx     = r_locked;
    w_fail_nx       = r_fail;
    w_busy_nx       = r_busy;
    w_osc_reset_nx  = r_osc_reset;
    w_last_count_nx = r_last_count;
    w_clr           = 1'b0;
    w_en            = 1'b0;

    case (r_state)
      S_OSC_RST: begin
        w_tim_nx = r_tim + 1'b1;
        if (r_tim == TIM_W'(OSC_RST_CYC - 1)) begin
          w_state_nx     = S_SETTLE;
          w_osc_reset_nx = 1'b0;
          w_tim_nx       = '0;
        end
      end
      S_SETTLE: begin
        w_clr    = 1'b1;
        w_tim_nx = r_tim + 1'b1;
        if (r_tim == TIM_W'(SETTLE - 1)) begin
          w_state_nx = S_MEASURE;
          w_tim_nx   = '0;
        end
      end
      S_MEASURE: begin
        w_en     = 1'b1;
        w_tim_nx = r_tim + 1'b1;
        if (r_tim == TIM_W'(WINDOW - 1)) begin
          w_state_nx = S_ADJUST;
          w_tim_nx   = '0;
        end
      end
      S_ADJUST: begin
        w_last_count_nx = w_count;
        w_tim_nx        = '0;
        if (w_in_tol) begin
          w_state_nx  = S_LOCKED;
          w_locked_nx = 1'b1;
          w_busy_nx   = 1'b0;
        end else if (w_step_fail) begin
          w_state_nx = S_FAIL;
          w_fail_nx  = 1'b1;
          w_busy_nx  = 1'b0;
        end else begin
          w_level_nx = w_level_step;
          w_iter_nx  = w_iter_inc;
          if (w_iter_inc == ITER_W'(MAX_ITER)) begin
            w_state_nx = S_FAIL;
            w_fail_nx  = 1'b1;
            w_busy_nx  = 1'b0;
          end else begin
            w_state_nx = S_SETTLE;
          end
        end
      end
      S_LOCKED: begin
`ifdef RING_CAL_TRACK_EN
        // Free-running settle/window/evaluate cycle on the tracking timer.
        w_tim_nx = r_tim + 1'b1;
        w_clr    = (r_tim < TIM_W'(SETTLE));
        w_en     = (r_tim >= TIM_W'(SETTLE)) && (r_tim < TIM_W'(SETTLE + WINDOW));
        if (r_tim == TIM_W'(SETTLE + WINDOW)) begin
          w_last_count_nx = w_count;
          w_tim_nx        = '0;
          if (!w_in_tol) begin
            w_locked_nx = 1'b0;
            if (w_step_fail || (ITER_W'(1) == ITER_W'(MAX_ITER))) begin
              w_state_nx = S_FAIL;
              w_fail_nx  = 1'b1;
              if (!w_step_fail) w_level_nx = w_level_step;
            end else begin
              w_level_nx = w_level_step;
              w_iter_nx  = ITER_W'(1);
              w_busy_nx  = 1'b1;
              w_state_nx = S_SETTLE;
            end
          end
        end
`endif
      end
      default: ;
    endcase

    if (w_start_ok && (r_state == S_IDLE || r_state == S_LOCKED || r_state == S_FAIL)) begin
      w_state_nx     = S_OSC_RST;
      w_level_nx     = w_init_clamp;
      w_iter_nx      = '0;
      w_locked_nx    = 1'b0;
      w_fail_nx      = 1'b0;
      w_busy_nx      = 1'b1;
      w_osc_reset_nx = 1'b1;
      w_tim_nx       = '0;
      w_clr          = 1'b0;
      w_en           = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_tim        <= '0;
      r_iter       <= '0;
      r_level      <= '0;
      r_locked     <= 1'b0;
      r_fail       <= 1'b0;
      r_busy       <= 1'b0;
      r_osc_reset  <= 1'b1;
      r_last_count <= '0;
    end else begin
      r_state      <= w_state_nx;
      r_tim        <= w_tim_nx;
      r_iter       <= w_iter_nx;
      r_level      <= w_level_nx;
      r_locked     <= w_locked_nx;
      r_fail       <= w_fail_nx;
      r_busy       <= w_busy_nx;
      r_osc_reset  <= w_osc_reset_nx;
      r_last_count <= w_last_count_nx;
    end
  end

  assign bus.osc_reset  = r_osc_reset;
  assign bus.trim       = level_to_therm(r_level);
  assign bus.level      = r_level;
  assign bus.busy       = r_busy;
  assign bus.locked     = r_locked;
  assign bus.fail       = r_fail;
  assign bus.last_count = r_last_count;

endmodule

`default_nettype wire

// File: tb/tb_ring_trim_cal.sv
// tb_ring_trim_cal: table-driven and sequence checks of ring_trim_cal against a level-dependent ring model.
// Revision 1.0
`default_nettype none

module tb_ring_trim_cal;

  logic clk;
  logic resetn;

  ring_trim_cal_if #(.CNT_W(16)) bus1 ();
  ring_trim_cal_if #(.CNT_W(16)) bus2 ();

  ring_trim_cal dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus1.slave)
  );

  ring_trim_cal #(.MAX_ITER(4)) dut_osc (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Ring model: mode 0 constant count, mode 1 count 80-2*level, mode 2 tracking bump.
  int mode      = 0;
  int cnt_const = 64;
  bit bump      = 1'b0;
  int ph        = 0;

  function automatic int model1(input int lvl);
    case (mode)
      0:       return cnt_const;
      1:       return 80 - 2 * lvl;
      default: return (lvl == 5 && bump) ? 85 : 64;
    endcase
  endfunction

  // N single-cycle pulses spread over every 1024 consecutive cycles.
  function automatic logic pulse(input int p, input int n);
    return (((p + 1) * n) / 1024) != ((p * n) / 1024);
  endfunction

  always @(negedge clk) begin
    ph = (ph + 1) % 1024;
    bus1.osc_div_in = pulse(ph, model1(int'(bus1.level)));
    bus2.osc_div_in = pulse(ph, bus2.level[0] ? 50 : 70);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    bus1.start = 1'b0;
    bus2.start = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic pulse_start1();
    @(negedge clk);
    bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
  endtask

  task automatic wait_idle1(input string name, input int budget);
    int cyc;
    cyc = 0;
    while (bus1.busy && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    chk({name, "_timeout"}, 64'(cyc >= budget), 64'd0);
  endtask

  typedef struct {
    string       name;
    int          init;
    int          tgt;
    int          tol;
    int          md;
    int          c;
    int          exp_level;
    bit          exp_locked;
    bit          exp_fail;
    logic [25:0] exp_trim;
    int          exp_last;
  } vec_t;

  vec_t vecs[6];

  initial begin
    bit seen_rst;
    int cyc;

    vecs[0] = '{"lock64",    5, 64,  2, 0,  64,  5, 1'b1, 1'b0, 26'h000001F,  64};
    vecs[1] = '{"stepdown",  0, 60,  1, 1,   0, 10, 1'b1, 1'b0, 26'h00003FF,  60};
    vecs[2] = '{"fast_ceil", 24, 50, 5, 0, 200, 26, 1'b0, 1'b1, 26'h3FFFFFF, 200};
    vecs[3] = '{"slow_floor", 2, 100, 3, 0, 10,  0, 1'b0, 1'b1, 26'h0000000,  10};
    vecs[4] = '{"tol_edge",  7, 62,  2, 0,  64,  7, 1'b1, 1'b0, 26'h000007F,  64};
    vecs[5] = '{"clamp_lo", 31,  3,  5, 0,   0, 26, 1'b1, 1'b0, 26'h3FFFFFF,   0};

    resetn = 1'b0;
    bus1.start = 1'b0; bus1.init_level = 5'd0; bus1.target_cnt = 16'd0; bus1.tol = 8'd0;
    bus2.start = 1'b0; bus2.init_level = 5'd4; bus2.target_cnt = 16'd60; bus2.tol = 8'd0;
    do_reset();

    chk("rst_osc_reset", 64'(bus1.osc_reset), 64'd1);
    chk("rst_trim",      64'(bus1.trim), 64'd0);
    chk("rst_level",     64'(bus1.level), 64'd0);
    chk("rst_busy",      64'(bus1.busy), 64'd0);
    chk("rst_locked",    64'(bus1.locked), 64'd0);
    chk("rst_fail",      64'(bus1.fail), 64'd0);
    chk("rst_last",      64'(bus1.last_count), 64'd0);

    // Start-to-lock latency and osc_reset release timing.
    mode = 0; cnt_const = 64;
    bus1.init_level = 5'd5; bus1.target_cnt = 16'd64; bus1.tol = 8'd2;
    pulse_start1();
    chk("lat_busy", 64'(bus1.busy), 64'd1);
    cyc = 0;
    while (!bus1.locked && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 15) chk("lat_oscrst_hi", 64'(bus1.osc_reset), 64'd1);
      if (cyc == 16) chk("lat_oscrst_lo", 64'(bus1.osc_reset), 64'd0);
    end
    chk("lat_cycles", 64'(cyc + 1), 64'd1106);
    chk("lat_busy_done", 64'(bus1.busy), 64'd0);

    // Start while busy is ignored; then reset mid-MEASURE clears everything.
    pulse_start1();
    repeat (200) @(negedge clk);
    chk("busy_mid", 64'(bus1.busy), 64'd1);
    pulse_start1();
    seen_rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus1.osc_reset) seen_rst = 1'b1;
    end
    chk("ignore_start", 64'(seen_rst), 64'd0);
    resetn = 1'b0;
    @(negedge clk);
    chk("midrst_osc_reset", 64'(bus1.osc_reset), 64'd1);
    chk("midrst_trim",      64'(bus1.trim), 64'd0);
    chk("midrst_busy",      64'(bus1.busy), 64'd0);
    chk("midrst_last",      64'(bus1.last_count), 64'd0);
    resetn = 1'b1;

    for (int v = 0; v < 6; v++) begin
      do_reset();
      mode = vecs[v].md;
      cnt_const = vecs[v].c;
      bus1.init_level = 5'(vecs[v].init);
      bus1.target_cnt = 16'(vecs[v].tgt);
      bus1.tol = 8'(vecs[v].tol);
      pulse_start1();
      wait_idle1(vecs[v].name, 40000);
      chk({vecs[v].name, "_level"},  64'(bus1.level), 64'(vecs[v].exp_level));
      chk({vecs[v].name, "_locked"}, 64'(bus1.locked), 64'(vecs[v].exp_locked));
      chk({vecs[v].name, "_fail"},   64'(bus1.fail), 64'(vecs[v].exp_fail));
      chk({vecs[v].name, "_trim"},   64'(bus1.trim), 64'(vecs[v].exp_trim));
      chk({vecs[v].name, "_last"},   64'(bus1.last_count), 64'(vecs[v].exp_last));
      chk({vecs[v].name, "_oscrst"}, 64'(bus1.osc_reset), 64'd0);
    end

    // Oscillating ring (70/50) with zero tolerance hits the 4-step limit.
    @(negedge clk);
    bus2.start = 1'b1;
    @(negedge clk);
    bus2.start = 1'b0;
    cyc = 0;
    while (bus2.busy && cyc < 10000) begin
      @(negedge clk);
      cyc++;
    end
    chk("osc_timeout", 64'(cyc >= 10000), 64'd0);
    chk("osc_fail",    64'(bus2.fail), 64'd1);
    chk("osc_locked",  64'(bus2.locked), 64'd0);
    chk("osc_level",   64'(bus2.level), 64'd4);
    chk("osc_last",    64'(bus2.last_count), 64'd50);

`ifdef RING_CAL_TRACK_EN
    do_reset();
    mode = 2; bump = 1'b0;
    bus1.init_level = 5'd5; bus1.target_cnt = 16'd64; bus1.tol = 8'd2;
    pulse_start1();
    wait_idle1("trk_lock", 5000);
    chk("trk_locked0", 64'(bus1.locked), 64'd1);
    bump = 1'b1;
    seen_rst = 1'b0;
    cyc = 0;
    while (bus1.locked && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (bus1.osc_reset) seen_rst = 1'b1;
    end
    chk("trk_drop", 64'(bus1.locked), 64'd0);
    chk("trk_step", 64'(bus1.level), 64'd6);
    cyc = 0;
    while (!bus1.locked && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (bus1.osc_reset) seen_rst = 1'b1;
    end
    chk("trk_relock", 64'(bus1.locked), 64'd1);
    chk("trk_level",  64'(bus1.level), 64'd6);
    chk("trk_fail",   64'(bus1.fail), 64'd0);
    chk("trk_no_rst", 64'(seen_rst), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
